// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM operation issuer.
//   RBM_DATA_WIDTH : operand/result word width used as the default everywhere
//   issuer_state_t : issue FSM states
//   ptr_w()        : pointer width for a FIFO of the given depth
package rbm_pkg;

   localparam int RBM_DATA_WIDTH = 128;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } issuer_state_t;

   // Address bits needed to index a power-of-two FIFO; never less than one.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rbm_op_issuer_if.sv
// Bundle of every non-clock/reset signal of rbm_op_issuer.
//   in_*     : operand packet stream into the issuer (valid/ready)
//   avm_*    : Avalon-MM write/readdatavalid path to the RBM compute slave
//   out_*    : result stream out of the issuer (valid/ready)
//   busy, err_unexpected, ops_issued : status
// Modport 'master' is the issuer's own view (it is the Avalon master);
// modport 'slave' is the view of everything around it.
interface rbm_op_issuer_if
   import rbm_pkg::*;
#(
   parameter int DATA_WIDTH = RBM_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;

   logic                  avm_write;
   logic [DATA_WIDTH-1:0] avm_writedata;
   logic                  avm_waitrequest;
   logic                  avm_readdatavalid;
   logic [DATA_WIDTH-1:0] avm_readdata;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   logic                  busy;
   logic                  err_unexpected;
   logic [CNT_WIDTH-1:0]  ops_issued;

   modport master (
      input  in_valid, in_data,
      output in_ready,
      output avm_write, avm_writedata,
      input  avm_waitrequest, avm_readdatavalid, avm_readdata,
      output out_valid, out_data,
      input  out_ready,
      output busy, err_unexpected, ops_issued
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready,
      input  avm_write, avm_writedata,
      output avm_waitrequest, avm_readdatavalid, avm_readdata,
      input  out_valid, out_data,
      output out_ready,
      input  busy, err_unexpected, ops_issued
   );

endinterface

// File: rtl/rbm_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
//   clk, reset : clock, synchronous active-high reset
//   push, push_data : write request/data (ignored when full unless popping)
//   pop, pop_data   : read request (ignored when empty) / head of queue
//   full, empty, count : occupancy
// DEPTH must be a power of two and at least 2 so the pointers wrap freely.
module rbm_sync_fifo
   import rbm_pkg::*;
#(
   parameter  int WIDTH = RBM_DATA_WIDTH,
   parameter  int DEPTH = 4,
   localparam int PW    = ptr_w(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO may still take a push in the cycle it is also popped.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: storage is deliberately left out of reset; count and pointers
   // decide what is valid, so resetting the array would only cost area.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/rbm_op_issuer.sv
// Avalon-MM master feeding the RBM compute slave.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rbm_op_issuer_if.master
//     in_*  operand packets are queued in a command FIFO
//     avm_* each packet is issued as one write; results come back on
//           readdatavalid in issue order and are queued in a result FIFO
//     out_* result FIFO drained on a valid/ready stream
//     busy / err_unexpected / ops_issued status
// Issue is credit based: a write only starts while outstanding results
// plus queued results are below RES_DEPTH, so the result FIFO never
// overflows. At most one write every two cycles.
// The interface instance must use the same DATA_WIDTH and CNT_WIDTH.
module rbm_op_issuer
   import rbm_pkg::*;
#(
   parameter int DATA_WIDTH = RBM_DATA_WIDTH,
   parameter int CMD_DEPTH  = 4,
   parameter int RES_DEPTH  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic           clk,
   input  logic           reset,
   rbm_op_issuer_if.master bus
);

   localparam int CMD_CW = ptr_w(CMD_DEPTH) + 1;
   localparam int OUT_W  = ptr_w(RES_DEPTH) + 1;
   localparam int CRD_W  = OUT_W + 1;
   localparam logic [CRD_W-1:0] CREDITS = CRD_W'(RES_DEPTH);

   issuer_state_t state, next_state;

   logic [DATA_WIDTH-1:0] cmd_head;
   logic                  cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic [CMD_CW-1:0]     cmd_count;

   logic [DATA_WIDTH-1:0] res_head;
   logic                  res_full, res_empty, res_push, res_pop;
   logic [OUT_W-1:0]      res_count;

   logic [OUT_W-1:0]      outstanding;
   logic [CRD_W-1:0]      credit_used;
   logic                  credit_ok;
   logic                  accept;
   logic                  strobe_ok;

   logic                  avm_write_q;
   logic [DATA_WIDTH-1:0] writedata_q;
   logic [CNT_WIDTH-1:0]  ops_issued_q;
   logic                  err_q;

   // ---------------------------------------------------------------- FIFOs
   // in_ready is forced low while reset is held so nothing is accepted into
   // a queue that is being cleared.
   assign bus.in_ready = ~reset & ~cmd_full;
   assign cmd_push     = bus.in_valid & bus.in_ready;

   rbm_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_push),
      .push_data (bus.in_data),
      .pop       (cmd_pop),
      .pop_data  (cmd_head),
      .full      (cmd_full),
      .empty     (cmd_empty),
      .count     (cmd_count)
   );

   // A strobe with nothing outstanding is dropped and flagged. The full
   // guard cannot trigger while credits are honoured; it keeps an
   // out-of-protocol slave from overwriting queued results.
   assign strobe_ok = bus.avm_readdatavalid & (outstanding != '0);
   assign res_push  = strobe_ok & ~res_full;
   assign res_pop   = bus.out_ready & ~res_empty;

   rbm_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (res_push),
      .push_data (bus.avm_readdata),
      .pop       (res_pop),
      .pop_data  (res_head),
      .full      (res_full),
      .empty     (res_empty),
      .count     (res_count)
   );

   // -------------------------------------------------------------- credits
   assign credit_used = CRD_W'(outstanding) + CRD_W'(res_count);
   assign credit_ok   = (credit_used < CREDITS);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      cmd_pop    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!cmd_empty && credit_ok) next_state = ISSUE;
         end
         ISSUE: begin
            if (!bus.avm_waitrequest) begin
               cmd_pop    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept = cmd_pop;

   // ------------------------------------------------- registered datapath
   // avm_write mirrors the next state so it rises together with ISSUE; the
   // write data is captured once on entry to ISSUE and then held through
   // any waitrequest stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         avm_write_q  <= 1'b0;
         writedata_q  <= '0;
         outstanding  <= '0;
         ops_issued_q <= '0;
         err_q        <= 1'b0;
      end else begin
         avm_write_q <= (next_state == ISSUE);
         if (state == IDLE && next_state == ISSUE) writedata_q <= cmd_head;

         // Accept and result in the same cycle cancel out.
         case ({accept, strobe_ok})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: ;
         endcase

         if (accept) ops_issued_q <= ops_issued_q + CNT_WIDTH'(1);
         if (bus.avm_readdatavalid && outstanding == '0) err_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.avm_write      = avm_write_q;
   assign bus.avm_writedata  = writedata_q;
   assign bus.out_valid      = ~res_empty;
   // Result storage is not reset, so the head is masked when nothing is queued.
   assign bus.out_data       = res_empty ? '0 : res_head;
   assign bus.busy           = (cmd_count != '0) | (outstanding != '0) | (res_count != '0);
   assign bus.err_unexpected = err_q;
   assign bus.ops_issued     = ops_issued_q;

endmodule

// File: tb/tb_rbm_op_issuer.sv
// Self-checking bench for rbm_op_issuer with a 3-cycle multiplying slave
// (readdata = writedata[95:64] * writedata[127:96]). Expected results are
// queued when packets are accepted and compared as results are popped.
module tb_rbm_op_issuer;
   import rbm_pkg::*;

   localparam int DW = RBM_DATA_WIDTH;
   localparam int CW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   rbm_op_issuer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   rbm_op_issuer #(
      .DATA_WIDTH (DW),
      .CMD_DEPTH  (4),
      .RES_DEPTH  (4),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total   = 0;
   int bad     = 0;
   int cyc     = 0;
   int acc_cnt = 0;
   int acc_cycle = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] slv_data [$];
   int            slv_due [$];
   logic          inj_pending = 1'b0;
   logic [DW-1:0] inj_data = '0;
   logic [DW-1:0] last_pkt = '0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Sampling/driving point: 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Slave return path: strobes a result 3 cycles after its write was accepted.
   initial begin
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (slv_due.size() > 0 && slv_due[0] == cyc) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = slv_data.pop_front();
            void'(slv_due.pop_front());
         end else if (inj_pending) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = inj_data;
            inj_pending           = 1'b0;
         end else begin
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // Mid-cycle monitor: slave write acceptance and scoreboard compare.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && bus.avm_write && !bus.avm_waitrequest) begin
            acc_cnt++;
            slv_data.push_back(DW'(bus.avm_writedata[95:64]) * DW'(bus.avm_writedata[127:96]));
            slv_due.push_back(cyc + 3);
         end
         if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else                   check("sb_data", bus.out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int   waited;
      logic ok;
      last_pkt     = {b, a, $urandom, $urandom};
      bus.in_data  = last_pkt;
      bus.in_valid = 1'b1;
      ok     = 1'b0;
      waited = 0;
      while (!ok && waited < 50) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok        = 1'b1;
            acc_cycle = cyc;
            exp_q.push_back(DW'(a) * DW'(b));
         end else begin
            waited++;
         end
      end
      if (!ok) check("send_timeout", ok, 1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((bus.busy || exp_q.size() != 0 || slv_due.size() != 0) && n < 200) begin
         step();
         n++;
      end
      check({tag, "_idle"}, (n < 200), 1);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      step();
      step();
      check("rst_in_ready", bus.in_ready, 0);
      reset = 1'b0;
      exp_q.delete();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      int a0;
      logic found;

      bus.in_valid        = 1'b0;
      bus.in_data         = '0;
      bus.avm_waitrequest = 1'b0;
      bus.out_ready       = 1'b1;

      // ---- reset state
      reset_dut();
      check("rst_in_ready_after", bus.in_ready, 1);
      check("rst_avm_write", bus.avm_write, 0);
      check("rst_writedata", bus.avm_writedata, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_err", bus.err_unexpected, 0);
      check("rst_ops", bus.ops_issued, 0);

      // ---- single op and latency
      send(3, 5);
      n0 = acc_cycle;
      for (int i = 0; i < 10; i++) begin
         if (bus.avm_write) break;
         step();
      end
      check("single_wr_lat", cyc - n0, 2);
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid) break;
         step();
      end
      check("single_out_lat", cyc - n0, 6);
      check("single_out_data", bus.out_data, 15);
      wait_idle("single");
      check("single_busy", bus.busy, 0);
      check("single_ops", bus.ops_issued, 1);

      // ---- waitrequest stall
      reset_dut();
      bus.avm_waitrequest = 1'b1;
      a0 = acc_cnt;
      send(7, 6);
      for (int i = 0; i < 10; i++) begin
         if (bus.avm_write) break;
         step();
      end
      for (int i = 0; i < 4; i++) begin
         check("wait_write_held", bus.avm_write, 1);
         check("wait_data_held", bus.avm_writedata, last_pkt);
         step();
      end
      check("wait_no_accept", acc_cnt - a0, 0);
      bus.avm_waitrequest = 1'b0;
      step();
      check("wait_write_drop", bus.avm_write, 0);
      wait_idle("wait");
      check("wait_one_accept", acc_cnt - a0, 1);
      check("wait_ops", bus.ops_issued, 1);

      // ---- credit backpressure
      reset_dut();
      bus.out_ready = 1'b0;
      a0 = acc_cnt;
      for (int i = 1; i <= 6; i++) send(i, 1);
      check("credit_in_ready_low", bus.in_ready, 0);
      repeat (30) step();
      check("credit_writes", acc_cnt - a0, 4);
      check("credit_ops", bus.ops_issued, 4);
      check("credit_res_count", dut.u_res_fifo.count, 4);
      check("credit_out_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      wait_idle("credit");
      check("credit_writes_all", acc_cnt - a0, 6);
      check("credit_ops_all", bus.ops_issued, 6);

      // ---- accept and result strobe in the same cycle
      reset_dut();
      send(2, 3);
      step();
      step();
      send(4, 5);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.avm_write && !bus.avm_waitrequest && bus.avm_readdatavalid) begin
            found = 1'b1;
            break;
         end
      end
      check("simul_coincide", found, 1);
      step();
      check("simul_outstanding", dut.outstanding, 1);
      wait_idle("simul");

      // ---- result FIFO push and pop in the same cycle
      bus.out_ready = 1'b0;
      send(6, 7);
      send(8, 9);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.avm_readdatavalid && bus.out_valid) begin
            bus.out_ready = 1'b1;
            found = 1'b1;
            break;
         end
         step();
      end
      check("pushpop_found", found, 1);
      step();
      check("pushpop_count", dut.u_res_fifo.count, 1);
      bus.out_ready = 1'b1;
      wait_idle("pushpop");

      // ---- unexpected result
      reset_dut();
      inj_data    = DW'(128'h55);
      inj_pending = 1'b1;
      step();
      step();
      check("unexp_out_valid", bus.out_valid, 0);
      check("unexp_err", bus.err_unexpected, 1);
      check("unexp_busy", bus.busy, 0);
      repeat (3) step();
      check("unexp_err_sticky", bus.err_unexpected, 1);
      reset_dut();
      check("unexp_err_cleared", bus.err_unexpected, 0);

      // ---- reset with two writes outstanding
      a0 = acc_cnt;
      send(10, 11);
      send(12, 13);
      for (int i = 0; i < 20; i++) begin
         if (acc_cnt - a0 == 2) break;
         step();
      end
      check("mid_outstanding", dut.outstanding, 2);
      reset = 1'b1;
      step();
      check("mid_in_ready", bus.in_ready, 0);
      check("mid_avm_write", bus.avm_write, 0);
      check("mid_writedata", bus.avm_writedata, 0);
      check("mid_out_valid", bus.out_valid, 0);
      check("mid_out_data", bus.out_data, 0);
      check("mid_busy", bus.busy, 0);
      check("mid_err", bus.err_unexpected, 0);
      check("mid_ops", bus.ops_issued, 0);
      reset = 1'b0;
      exp_q.delete();
      step();
      step();
      check("stale_err", bus.err_unexpected, 1);
      check("stale_out_valid", bus.out_valid, 0);
      check("stale_ops", bus.ops_issued, 0);
      check("stale_busy", bus.busy, 0);
      check("end_slave_drained", slv_due.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rbm_op_issuer.md
# rbm_op_issuer

Avalon-MM master that sits directly upstream of the RBM compute slave. It accepts 128-bit operand packets on a valid/ready stream and queues them. It issues each packet as a single Avalon write, tracks how many results are still outstanding, and collects the slave's `readdatavalid` results into a result queue drained on a valid/ready output stream. Credit-based issue guarantees the result queue never overflows.

## Interface
- `DATA_WIDTH`, 128: operand/result word width.
- `CMD_DEPTH`, 4: command FIFO depth (power of 2).
- `RES_DEPTH`, 4: result FIFO depth (power of 2); also the total credit pool.
- `CNT_WIDTH`, 16: width of the issued-operation counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `in_valid`  in  1  operand packet valid
- `in_ready`  out  1  command FIFO not full
- `in_data`  in  DATA_WIDTH  operand packet
- `avm_write`  out  1  Avalon write request to compute slave
- `avm_writedata`  out  DATA_WIDTH  packet being issued
- `avm_waitrequest`  in  1  slave stall
- `avm_readdatavalid`  in  1  result strobe from slave, one cycle per result
- `avm_readdata`  in  DATA_WIDTH  result word
- `out_valid`  out  1  result FIFO not empty
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  DATA_WIDTH  head of result FIFO
- `busy`  out  1  command FIFO non-empty, or outstanding != 0, or result FIFO non-empty
- `err_unexpected`  out  1  sticky: result strobe arrived with outstanding == 0
- `ops_issued`  out  CNT_WIDTH  count of accepted writes, wraps modulo 2^CNT_WIDTH

## Operation
- **Input stream:** packet enqueued when `in_valid & in_ready`.
- **FSM states:**
  - IDLE: `avm_write`=0. Moves to ISSUE when the command FIFO is non-empty and `outstanding + res_count < RES_DEPTH`.
  - ISSUE: `avm_write`=1 and `avm_writedata` = FIFO head.
    - If `avm_waitrequest`=0, the write is accepted: pop the command FIFO, `outstanding++`, `ops_issued++`, then return to IDLE.
    - Otherwise stay in ISSUE with data held stable.
  - Back-to-back issue is not required; at most one write every 2 cycles.
- **Outstanding counter:** width clog2(RES_DEPTH)+1. Accept and result strobe in the same cycle leaves it unchanged.
- **Result strobe with outstanding > 0:** push `avm_readdata` into the result FIFO and decrement.
- **Result strobe with outstanding == 0:** drop the data and set `err_unexpected`. It is cleared only by reset.
- **Result FIFO:** pops on `out_valid & out_ready`. Push and pop in the same cycle is legal when full or empty+bypass-free: count unchanged when both occur on a non-empty FIFO.
- **Ordering:** results are returned in issue order. The slave is in-order; this block does no reordering.

## Timing
- Reset values: `in_ready`=0 during reset, then 1 from the first cycle after reset. All other outputs are 0. FSM goes to IDLE; both FIFOs, `outstanding`, and `ops_issued` go to 0.
- Reset mid-operation: everything is discarded, in-flight results included. A stale strobe after reset sets `err_unexpected`.
- Packet accepted at cycle N: earliest `avm_write`=1 is at N+2 (FIFO write at N+1, FSM transition at N+1, registered output at N+2).
- Result strobe at cycle M: `out_valid`=1 at M+1.
- With a 3-cycle slave and no stalls, `in_valid` to `out_valid` is 6 cycles.
- `avm_write` and `avm_writedata` are registered outputs. They are never deasserted or changed while `avm_waitrequest`=1.
- Credit stall: when `outstanding + res_count == RES_DEPTH`, no new write is issued until a result pops.

## Structure
- Package `rbm_pkg` holds:
  - `RBM_DATA_WIDTH` = 128
  - the `issuer_state_t` enum {IDLE, ISSUE}
  - a `ptr_w` helper function (clog2)
- Sub-module `rbm_sync_fifo`: parameterised width/depth, registered count, full/empty. It is instantiated twice, for commands and for results.

## Test plan
The slave model computes `readdata = writedata[95:64] * writedata[127:96]` with 3-cycle latency.

- **Single op:** send 1 packet with [95:64]=3, [127:96]=5 → `out_data`=15 at cycle 6; `ops_issued`=1; `busy` returns to 0.
- **Waitrequest:** hold `avm_waitrequest` for 4 cycles → `avm_writedata` stable throughout; exactly one accept; `ops_issued`=1.
- **Credit backpressure:** hold `out_ready`=0 and send 6 packets → exactly 4 writes issued; `in_ready` drops after the command FIFO fills. Release `out_ready` → results 1..6 emerge in order.
- **Simultaneous events:** arrange an accept and a result strobe in the same cycle → `outstanding` unchanged. A push and pop on the result FIFO in the same cycle → count unchanged.
- **Unexpected result:** strobe `avm_readdatavalid` with nothing outstanding → data dropped, `out_valid` stays 0, `err_unexpected`=1 until reset.
- **Reset mid-flight:** assert reset with 2 writes outstanding → all outputs 0 on the next cycle, and `ops_issued`=0 afterwards.
